int_iq_slot_allocator: RTL and testbench
========================================

// Module: int_iq_slot_allocator
// PURPOSE
//  Upstream companion of the INT issue-queue selector. Owns the INT IQ entry-valid bitmap.
//  Hands out up to two free slot indices per cycle to rename/dispatch.
//  Frees slots once the issue stage confirms them, and clears everything on branch-miss flush.
//  Drives entry_valid[] and dispatch_slot_idx0/1 + dispatch_instr0/1_valid into the selector.
// PARAMETERS
//  IQ_NUM    8  number of INT IQ entries (= Falco_pkg::INT_IQ_NUM)
//  IQ_WIDTH  3  slot index width, $clog2(IQ_NUM)
// PORTS
//  clk                    in   1         core clock
//  rst                    in   1         synchronous reset, active-high
//  dispatch_req0          in   1         dispatch lane 0 wants a slot
//  dispatch_req1          in   1         dispatch lane 1 wants a slot
//  dispatch_ready         out  1         >=2 free slots; dispatch may proceed
//  dispatch_slot_idx0     out  IQ_WIDTH  slot granted to lane 0
//  dispatch_slot_idx1     out  IQ_WIDTH  slot granted to lane 1
//  dispatch_instr0_valid  out  1         lane 0 allocation takes effect this cycle
//  dispatch_instr1_valid  out  1         lane 1 allocation takes effect this cycle
//  free_slot_idx0         in   IQ_WIDTH  issued slot confirmed (past kill window), port 0
//  free_slot_idx1         in   IQ_WIDTH  issued slot confirmed, port 1
//  free_valid0            in   1         free_slot_idx0 valid
//  free_valid1            in   1         free_slot_idx1 valid
//  branch_miss_flush      in   1         squash all IQ entries
//  entry_valid            out  IQ_NUM    per-slot occupied bitmap (unpacked logic [IQ_NUM])
//  free_count             out  IQ_WIDTH+1 number of unoccupied slots
// BEHAVIOUR
//  - Reset: entry_valid all 0, free_count=IQ_NUM, dispatch_ready=1, idx0=0, idx1=1, instr*_valid=0.
//  - State: registered valid bitmap only; all outputs are combinational from bitmap + inputs.
//  - Slot pick: idx0 = lowest-index free slot; idx1 = second-lowest free slot.
//    If fewer than 2 are free, idx0/idx1 = 0 and dispatch_ready=0.
//  - dispatch_ready = (free_count >= 2); all-or-nothing, no single-lane grant.
//  - dispatch_instrN_valid = dispatch_reqN & dispatch_ready & ~branch_miss_flush.
//    Lanes are independent; req1 without req0 still uses idx1.
//  - Next bitmap, priority high->low:
//    rst -> all 0;
//    branch_miss_flush -> all 0 (frees and dispatches that cycle dropped);
//    else valid[i] <= (valid[i] & ~freed[i]) | alloc[i],
//    freed[i] = (free_valid0 & idx0==i) | (free_valid1 & idx1==i).
//  - Latency: alloc visible on entry_valid next cycle. A freed slot is reusable next cycle,
//    never the same cycle (no free->alloc bypass).
//  - Boundary: free of an already-invalid slot is a no-op.
//    free_slot_idx0==free_slot_idx1 with both valid frees once.
//    Alloc never targets a valid slot, so alloc/free cannot collide.
//    Full (free_count=0): ready=0, bitmap holds except frees.
//  - Reset/flush mid-dispatch: in-flight grants are void; no partial state survives.
// CONFIGURATION
//  INT_IQ_ALLOC_STALL_CNT_EN defined:
//    adds output alloc_stall_cnt [31:0]; reset 0; +1 each cycle with
//    (dispatch_req0|dispatch_req1) & ~dispatch_ready & ~branch_miss_flush;
//    saturates at 32'hFFFF_FFFF.
//  Not defined: port absent, no counter logic.
// TESTING
//  1. Reset -> free_count=8, ready=1, idx0=0, idx1=1, entry_valid=0.
//  2. 4 cycles req0=req1=1 -> slots {0,1},{2,3},{4,5},{6,7} granted; then free_count=0, ready=0.
//  3. Full, free 3 and 5 same cycle -> next cycle idx0=3, idx1=5, ready=1, free_count=2.
//  4. 7 valid, free slot 2 -> free_count=1, ready=0, instr*_valid=0 despite reqs.
//  5. Half full + flush with req0/1 and free_valid0 -> instr*_valid=0; next cycle all free.
//  6. STALL_CNT_EN: 3 blocked req cycles (one coincident with flush) -> alloc_stall_cnt=2.

Source files
------------

// File: rtl/int_iq_slot_allocator_if.sv
// ----------------------------------------------------------------------------
// int_iq_slot_allocator_if
//   Handshake bundle between rename/dispatch + issue stage (master) and the
//   INT IQ slot allocator (slave).
//   master drives : dispatch_req0/1, free_slot_idx0/1, free_valid0/1
//   slave drives  : dispatch_ready, dispatch_slot_idx0/1,
//                   dispatch_instr0_valid, dispatch_instr1_valid
// ----------------------------------------------------------------------------
interface int_iq_slot_allocator_if #(
  parameter int IQ_WIDTH = 3
);
  logic                dispatch_req0;
  logic                dispatch_req1;
  logic                dispatch_ready;
  logic [IQ_WIDTH-1:0] dispatch_slot_idx0;
  logic [IQ_WIDTH-1:0] dispatch_slot_idx1;
  logic                dispatch_instr0_valid;
  logic                dispatch_instr1_valid;
  logic [IQ_WIDTH-1:0] free_slot_idx0;
  logic [IQ_WIDTH-1:0] free_slot_idx1;
  logic                free_valid0;
  logic                free_valid1;

  modport master (
    output dispatch_req0, dispatch_req1,
    output free_slot_idx0, free_slot_idx1, free_valid0, free_valid1,
    input  dispatch_ready, dispatch_slot_idx0, dispatch_slot_idx1,
    input  dispatch_instr0_valid, dispatch_instr1_valid
  );

  modport slave (
    input  dispatch_req0, dispatch_req1,
    input  free_slot_idx0, free_slot_idx1, free_valid0, free_valid1,
    output dispatch_ready, dispatch_slot_idx0, dispatch_slot_idx1,
    output dispatch_instr0_valid, dispatch_instr1_valid
  );
endinterface

// File: rtl/int_iq_slot_allocator.sv
// ----------------------------------------------------------------------------
// int_iq_slot_allocator
//   Owns the INT issue-queue entry-valid bitmap. Hands out up to two free slot
//   indices per cycle to dispatch, frees slots confirmed by the issue stage,
//   and clears every entry on a branch-miss flush.
//
//   Ports
//     clk                : core clock
//     rst                : synchronous reset, active-high
//     bus (slave)        : dispatch request/grant and issue-free handshake
//     branch_miss_flush  : squash all IQ entries
//     entry_valid        : per-slot occupied bitmap
//     free_count         : number of unoccupied slots
//     alloc_stall_cnt    : (only with INT_IQ_ALLOC_STALL_CNT_EN) saturating
//                          count of cycles a request was blocked by !ready
//
//   Optional feature macro: INT_IQ_ALLOC_STALL_CNT_EN
// ----------------------------------------------------------------------------
module int_iq_slot_allocator #(
  parameter int IQ_NUM   = 8,
  parameter int IQ_WIDTH = $clog2(IQ_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  int_iq_slot_allocator_if.slave bus,
  input  logic                  branch_miss_flush,
  output logic                  entry_valid [IQ_NUM],
`ifdef INT_IQ_ALLOC_STALL_CNT_EN
  output logic [31:0]           alloc_stall_cnt,
`endif
  output logic [IQ_WIDTH:0]     free_count
);

  logic [IQ_NUM-1:0]   valid_q;
  logic [IQ_NUM-1:0]   alloc_mask;
  logic [IQ_NUM-1:0]   freed_mask;
  logic [IQ_WIDTH-1:0] pick0;
  logic [IQ_WIDTH-1:0] pick1;
  logic                have0;
  logic                have1;
  logic                ready;
  logic                grant0;
  logic                grant1;

  // Occupancy count and the two lowest free indices, scanned low to high.
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    free_count = '0;
    pick0      = '0;
    pick1      = '0;
    have0      = 1'b0;
    have1      = 1'b0;
    for (int i = 0; i < IQ_NUM; i++) begin
      free_count = free_count + (IQ_WIDTH+1)'(!valid_q[i]);
      if (!valid_q[i]) begin
        if (!have0) begin
          pick0 = IQ_WIDTH'(i);
          have0 = 1'b1;
        end else if (!have1) begin
          pick1 = IQ_WIDTH'(i);
          have1 = 1'b1;
        end
      end
    end
  end

  // All-or-nothing: with fewer than two free slots neither lane is granted,
  // which keeps dispatch groups in order without a single-lane path.
  assign ready  = (free_count >= (IQ_WIDTH+1)'(2));
  assign grant0 = bus.dispatch_req0 & ready & ~branch_miss_flush;
  assign grant1 = bus.dispatch_req1 & ready & ~branch_miss_flush;

  assign bus.dispatch_ready        = ready;
  assign bus.dispatch_slot_idx0    = ready ? pick0 : '0;
  assign bus.dispatch_slot_idx1    = ready ? pick1 : '0;
  assign bus.dispatch_instr0_valid = grant0;
  assign bus.dispatch_instr1_valid = grant1;

  // Lane 1 always takes the second free slot, even without a lane-0 request,
  // so the index a lane sees never depends on the other lane's request.
  // Frees of already-empty slots or duplicate indices fold into one clear.
  always_comb begin
    alloc_mask = '0;
    freed_mask = '0;
    for (int i = 0; i < IQ_NUM; i++) begin
      alloc_mask[i] = (grant0 && pick0 == IQ_WIDTH'(i)) ||
                      (grant1 && pick1 == IQ_WIDTH'(i));
      freed_mask[i] = (bus.free_valid0 && bus.free_slot_idx0 == IQ_WIDTH'(i)) ||
                      (bus.free_valid1 && bus.free_slot_idx1 == IQ_WIDTH'(i));
    end
  end

  // Picks only target empty slots, so alloc and free never hit the same bit;
  // a freed slot shows as free only from the next cycle on.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || branch_miss_flush) begin
      valid_q <= '0;
    end else begin
      valid_q <= (valid_q & ~freed_mask) | alloc_mask;
    end
  end

  always_comb begin
    for (int i = 0; i < IQ_NUM; i++) begin
      entry_valid[i] = valid_q[i];
    end
  end

`ifdef INT_IQ_ALLOC_STALL_CNT_EN
  logic stall;
  assign stall = (bus.dispatch_req0 | bus.dispatch_req1) & ~ready & ~branch_miss_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_stall_cnt <= '0;
    end else if (stall && alloc_stall_cnt != 32'hFFFF_FFFF) begin
      alloc_stall_cnt <= alloc_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_int_iq_slot_allocator.sv
// ----------------------------------------------------------------------------
// tb_int_iq_slot_allocator
//   Directed self-checking bench for int_iq_slot_allocator (IQ_NUM=8).
//   Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_int_iq_slot_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic       branch_miss_flush;
  logic       entry_valid [8];
  logic [3:0] free_count;
`ifdef INT_IQ_ALLOC_STALL_CNT_EN
  logic [31:0] alloc_stall_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  int_iq_slot_allocator_if #(.IQ_WIDTH(3)) bus ();

  int_iq_slot_allocator #(.IQ_NUM(8), .IQ_WIDTH(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .branch_miss_flush (branch_miss_flush),
    .entry_valid       (entry_valid),
`ifdef INT_IQ_ALLOC_STALL_CNT_EN
    .alloc_stall_cnt   (alloc_stall_cnt),
`endif
    .free_count        (free_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ev_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = entry_valid[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic r1,
                       input logic fv0, input logic [2:0] fi0,
                       input logic fv1, input logic [2:0] fi1,
                       input logic fl);
    bus.dispatch_req0  = r0;
    bus.dispatch_req1  = r1;
    bus.free_valid0    = fv0;
    bus.free_slot_idx0 = fi0;
    bus.free_valid1    = fv1;
    bus.free_slot_idx1 = fi1;
    branch_miss_flush  = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // 1. Reset state
    do_reset();
    check("rst_free_count", 32'(free_count), 32'd8);
    check("rst_ready", 32'(bus.dispatch_ready), 32'd1);
    check("rst_idx0", 32'(bus.dispatch_slot_idx0), 32'd0);
    check("rst_idx1", 32'(bus.dispatch_slot_idx1), 32'd1);
    check("rst_ev", 32'(ev_vec()), 32'h00);
    check("rst_v0", 32'(bus.dispatch_instr0_valid), 32'd0);
    check("rst_v1", 32'(bus.dispatch_instr1_valid), 32'd0);

    // 2. Fill in pairs {0,1},{2,3},{4,5},{6,7}
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      check($sformatf("fill%0d_idx0", k), 32'(bus.dispatch_slot_idx0), 32'(2*k));
      check($sformatf("fill%0d_idx1", k), 32'(bus.dispatch_slot_idx1), 32'(2*k+1));
      check($sformatf("fill%0d_v0", k), 32'(bus.dispatch_instr0_valid), 32'd1);
      check($sformatf("fill%0d_v1", k), 32'(bus.dispatch_instr1_valid), 32'd1);
      tick();
    end
    check("full_ev", 32'(ev_vec()), 32'hFF);
    check("full_free_count", 32'(free_count), 32'd0);
    check("full_ready", 32'(bus.dispatch_ready), 32'd0);
    check("full_idx0", 32'(bus.dispatch_slot_idx0), 32'd0);
    check("full_idx1", 32'(bus.dispatch_slot_idx1), 32'd0);
    check("full_v0", 32'(bus.dispatch_instr0_valid), 32'd0);
    check("full_v1", 32'(bus.dispatch_instr1_valid), 32'd0);
    tick();
    check("full_hold_ev", 32'(ev_vec()), 32'hFF);

    // 3. Full, free 3 and 5 together; no same-cycle reuse
    drive(1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 3'd5, 1'b0);
    check("free35_no_bypass_ready", 32'(bus.dispatch_ready), 32'd0);
    check("free35_no_bypass_v0", 32'(bus.dispatch_instr0_valid), 32'd0);
    tick();
    idle();
    check("free35_ev", 32'(ev_vec()), 32'hD7);
    check("free35_idx0", 32'(bus.dispatch_slot_idx0), 32'd3);
    check("free35_idx1", 32'(bus.dispatch_slot_idx1), 32'd5);
    check("free35_ready", 32'(bus.dispatch_ready), 32'd1);
    check("free35_count", 32'(free_count), 32'd2);

    // Refill 3 and 5
    drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    idle();
    check("refill_ev", 32'(ev_vec()), 32'hFF);

    // 4. Free slot 2 -> one free slot, dispatch blocked
    drive(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    check("seven_count", 32'(free_count), 32'd1);
    check("seven_ready", 32'(bus.dispatch_ready), 32'd0);
    check("seven_v0", 32'(bus.dispatch_instr0_valid), 32'd0);
    check("seven_v1", 32'(bus.dispatch_instr1_valid), 32'd0);
    check("seven_idx0", 32'(bus.dispatch_slot_idx0), 32'd0);
    tick();
    check("seven_hold_ev", 32'(ev_vec()), 32'hFB);

    // Free of an already-empty slot (2) is a no-op; same index on both ports frees once
    drive(1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2, 1'b0);
    tick();
    check("dup_empty_ev", 32'(ev_vec()), 32'hFB);
    drive(1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 3'd4, 1'b0);
    tick();
    idle();
    check("dup_free_ev", 32'(ev_vec()), 32'hEB);
    check("dup_free_count", 32'(free_count), 32'd2);
    check("dup_idx0", 32'(bus.dispatch_slot_idx0), 32'd2);
    check("dup_idx1", 32'(bus.dispatch_slot_idx1), 32'd4);

    // 5. Half full, then flush with reqs and a free in the same cycle
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    tick();
    idle();
    check("half_ev", 32'(ev_vec()), 32'h0F);
    drive(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1);
    check("flush_v0", 32'(bus.dispatch_instr0_valid), 32'd0);
    check("flush_v1", 32'(bus.dispatch_instr1_valid), 32'd0);
    check("flush_ready", 32'(bus.dispatch_ready), 32'd1);
    tick();
    idle();
    check("post_flush_ev", 32'(ev_vec()), 32'h00);
    check("post_flush_count", 32'(free_count), 32'd8);

    // Lane 1 alone still takes the second free slot
    drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    check("lane1_v0", 32'(bus.dispatch_instr0_valid), 32'd0);
    check("lane1_v1", 32'(bus.dispatch_instr1_valid), 32'd1);
    check("lane1_idx1", 32'(bus.dispatch_slot_idx1), 32'd1);
    tick();
    idle();
    check("lane1_ev", 32'(ev_vec()), 32'h02);
    check("lane1_next_idx0", 32'(bus.dispatch_slot_idx0), 32'd0);
    check("lane1_next_idx1", 32'(bus.dispatch_slot_idx1), 32'd2);

    // Reset mid-dispatch voids the grant
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    check("rst_mid_ev", 32'(ev_vec()), 32'h00);

`ifdef INT_IQ_ALLOC_STALL_CNT_EN
    // 6. Three blocked request cycles, the last one with flush -> count 2
    do_reset();
    check("stall_rst", alloc_stall_cnt, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    check("stall_fill_cnt", alloc_stall_cnt, 32'd0);
    tick();
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    tick();
    idle();
    check("stall_cnt", alloc_stall_cnt, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
